// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load and en bit strobe
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             en,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_shifted;
   logic [CW-1:0]    cnt;
   logic             load_acc;
   logic             step;
   logic             frame_end;
`ifdef SER_PARITY_EN
   logic             parity;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_acc  = 1'b0;
      step      = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               load_acc  = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (en) begin
               step = 1'b1;
               if (cnt == LAST) begin
`ifdef SER_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = IDLE;
                  frame_end = 1'b1;
`endif
               end
            end
         end
`ifdef SER_PARITY_EN
         PAR: begin
            if (en) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // The register always presents the current bit at one end, so a shift moves the next bit into place.
   assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg <= '0;
         cnt   <= '0;
         done  <= 1'b0;
`ifdef SER_PARITY_EN
         parity <= 1'b0;
`endif
      end else begin
         done <= frame_end;
         if (load_acc) begin
            shreg <= din;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            parity <= ^din;
`endif
         end else if (step) begin
            shreg <= shreg_shifted;
            // Hold on the last bit so a power-of-two WIDTH never wraps outside the load clear.
            if (cnt != LAST) begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      sout = 1'b0;
      case (state)
         SHIFT:   sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`ifdef SER_PARITY_EN
         PAR:     sout = parity;
`endif
         default: sout = 1'b0;
      endcase
   end

   assign load_ready = (state == IDLE);
   assign busy       = (state != IDLE);
   assign sout_valid = (state != IDLE);

endmodule
